// File: rtl/rvfi_insn_seq_check.sv
// Sequential RVFI instruction checker: captures retirements into a FIFO, replays each one
// to an external multi-cycle spec model and reports mismatch masks, counters and first failure.
module rvfi_insn_seq_check #(
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int NRET    = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   check,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*ILEN-1:0]   rvfi_insn,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*5-1:0]      rvfi_rs1_addr,
  input  logic [NRET*5-1:0]      rvfi_rs2_addr,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_mem_wdata,
  input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask,
  input  logic [NRET-1:0]        rvfi_trap,
  output logic                   spec_req_valid,
  input  logic                   spec_req_ready,
  output logic [ILEN-1:0]        spec_req_insn,
  output logic [XLEN-1:0]        spec_req_pc,
  output logic [XLEN-1:0]        spec_req_rs1,
  output logic [XLEN-1:0]        spec_req_rs2,
  output logic [XLEN-1:0]        spec_req_mem_rdata,
  input  logic                   spec_rsp_valid,
  input  logic                   spec_rsp_trap,
  input  logic [4:0]             spec_rsp_rd_addr,
  input  logic [XLEN-1:0]        spec_rsp_rd_wdata,
  input  logic [XLEN-1:0]        spec_rsp_pc_wdata,
  input  logic [XLEN-1:0]        spec_rsp_mem_addr,
  input  logic [XLEN/8-1:0]      spec_rsp_mem_wmask,
  input  logic [XLEN-1:0]        spec_rsp_mem_wdata,
  output logic                   result_valid,
  output logic [5:0]             result_mask,
  output logic [XLEN-1:0]        result_pc,
  output logic [15:0]            err_count,
  output logic [31:0]            checked_count,
  output logic                   overflow,
  output logic                   first_err_valid,
  output logic [XLEN-1:0]        first_err_pc,
  output logic [5:0]             first_err_mask
);

  localparam int BW = XLEN / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = $clog2(DEPTH + NRET + 1) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic            trap;
    logic [ILEN-1:0] insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [BW-1:0]   mem_wmask;
  } entry_t;

  typedef struct packed {
    logic            trap;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [BW-1:0]   mem_wmask;
  } cmp_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CMP} state_t;

  entry_t          fifo_mem [DEPTH];
  entry_t          head;
  entry_t          cap      [NRET];
  logic [PW-1:0]   cap_addr [NRET];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [KW-1:0]   fifo_cnt, push_cnt, free_cnt;
  logic            pop, push_ok, push_drop;
  state_t          state;
  cmp_t            infl;
  logic [TW-1:0]   tmr;
  logic            cmp_done;
  logic [5:0]      cmp_mask;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [5:0] check_mask(input cmp_t e, input logic s_trap,
                                            input logic [4:0] s_rd_addr,
                                            input logic [XLEN-1:0] s_rd_wdata,
                                            input logic [XLEN-1:0] s_pc_wdata,
                                            input logic [XLEN-1:0] s_mem_addr,
                                            input logic [BW-1:0] s_wmask,
                                            input logic [XLEN-1:0] s_wdata);
    logic [5:0] m;
    m    = '0;
    m[0] = (e.trap != s_trap);
    // A trapping spec result leaves the architectural effects undefined; only trap agreement matters.
    if (!s_trap) begin
      m[1] = (e.rd_addr != s_rd_addr);
      m[2] = (e.rd_wdata != s_rd_wdata);
      m[3] = (e.pc_wdata != s_pc_wdata);
      for (int b = 0; b < BW; b++) begin
        if (s_wmask[b] && (!e.mem_wmask[b] || (e.mem_wdata[b*8 +: 8] != s_wdata[b*8 +: 8])))
          m[4] = 1'b1;
      end
      if ((s_wmask != '0) && (e.mem_addr != s_mem_addr))
        m[4] = 1'b1;
    end
    return m;
  endfunction

  // capture stage: pack valid channels into consecutive FIFO slots in channel order
  always_comb begin
    push_cnt = '0;
    for (int c = 0; c < NRET; c++) begin
      cap_addr[c]       = wr_ptr + push_cnt[PW-1:0];
      cap[c].trap       = rvfi_trap[c];
      cap[c].insn       = rvfi_insn[c*ILEN +: ILEN];
      cap[c].pc_rdata   = rvfi_pc_rdata[c*XLEN +: XLEN];
      cap[c].pc_wdata   = rvfi_pc_wdata[c*XLEN +: XLEN];
      cap[c].rs1_rdata  = (rvfi_rs1_addr[c*5 +: 5] == 5'd0) ? '0 : rvfi_rs1_rdata[c*XLEN +: XLEN];
      cap[c].rs2_rdata  = (rvfi_rs2_addr[c*5 +: 5] == 5'd0) ? '0 : rvfi_rs2_rdata[c*XLEN +: XLEN];
      cap[c].rd_addr    = rvfi_rd_addr[c*5 +: 5];
      cap[c].rd_wdata   = rvfi_rd_wdata[c*XLEN +: XLEN];
      cap[c].mem_addr   = rvfi_mem_addr[c*XLEN +: XLEN];
      cap[c].mem_rdata  = rvfi_mem_rdata[c*XLEN +: XLEN];
      cap[c].mem_wdata  = rvfi_mem_wdata[c*XLEN +: XLEN];
      cap[c].mem_wmask  = rvfi_mem_wmask[c*BW +: BW];
      if (rvfi_valid[c]) push_cnt = push_cnt + KW'(1);
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign pop       = (state == REQ) && spec_req_ready;
  assign free_cnt  = KW'(DEPTH) - fifo_cnt + KW'(pop);
  assign push_ok   = check && (push_cnt != '0) && (push_cnt <= free_cnt);
  assign push_drop = check && (push_cnt > free_cnt);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      for (int c = 0; c < NRET; c++) begin
        if (rvfi_valid[c]) fifo_mem[cap_addr[c]] <= cap[c];
      end
    end
  end

  // request stage: head is presented until the spec model takes it
  assign spec_req_valid     = (state == REQ);
  assign spec_req_insn      = spec_req_valid ? head.insn      : '0;
  assign spec_req_pc        = spec_req_valid ? head.pc_rdata  : '0;
  assign spec_req_rs1       = spec_req_valid ? head.rs1_rdata : '0;
  assign spec_req_rs2       = spec_req_valid ? head.rs2_rdata : '0;
  assign spec_req_mem_rdata = spec_req_valid ? head.mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (pop) begin
      infl.trap      <= head.trap;
      infl.pc_rdata  <= head.pc_rdata;
      infl.pc_wdata  <= head.pc_wdata;
      infl.rd_addr   <= head.rd_addr;
      infl.rd_wdata  <= head.rd_wdata;
      infl.mem_addr  <= head.mem_addr;
      infl.mem_wdata <= head.mem_wdata;
      infl.mem_wmask <= head.mem_wmask;
    end
  end

  // compare stage: a response wins over a timeout landing in the same cycle
  assign cmp_done = (state == WAIT) && (spec_rsp_valid || (tmr == TW'(TIMEOUT - 1)));
  assign cmp_mask = spec_rsp_valid
                  ? check_mask(infl, spec_rsp_trap, spec_rsp_rd_addr, spec_rsp_rd_wdata,
                               spec_rsp_pc_wdata, spec_rsp_mem_addr, spec_rsp_mem_wmask,
                               spec_rsp_mem_wdata)
                  : 6'b100000;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      fifo_cnt        <= '0;
      overflow        <= 1'b0;
      state           <= IDLE;
      tmr             <= '0;
      result_valid    <= 1'b0;
      result_mask     <= '0;
      result_pc       <= '0;
      err_count       <= '0;
      checked_count   <= '0;
      first_err_valid <= 1'b0;
      first_err_pc    <= '0;
      first_err_mask  <= '0;
    end else begin
      fifo_cnt     <= fifo_cnt + (push_ok ? push_cnt : '0) - KW'(pop);
      result_valid <= cmp_done;
      if (push_ok)   wr_ptr   <= wr_ptr + push_cnt[PW-1:0];
      if (pop)       rd_ptr   <= rd_ptr + PW'(1);
      if (push_drop) overflow <= 1'b1;
      case (state)
        IDLE: if ((fifo_cnt != '0) || push_ok) state <= REQ;
        REQ: begin
          if (pop) begin
            state <= WAIT;
            tmr   <= '0;
          end
        end
        WAIT: begin
          if (cmp_done) state <= CMP;
          else          tmr   <= tmr + TW'(1);
        end
        default: state <= ((fifo_cnt != '0) || push_ok) ? REQ : IDLE;
      endcase
      if (cmp_done) begin
        result_mask   <= cmp_mask;
        result_pc     <= infl.pc_rdata;
        checked_count <= checked_count + 32'd1;
        if (cmp_mask != '0) begin
          err_count <= sat_inc16(err_count);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_pc    <= infl.pc_rdata;
            first_err_mask  <= cmp_mask;
          end
        end
      end
    end
  end

endmodule
